// File: rtl/pciecfg_resp_tx_if.sv
// Config-entry type and the FIFO-side / AXI-Stream-side bundle of the response serializer.
package pciecfg_resp_tx_pkg;
  typedef struct packed {
    logic [3:0]  opcode;
    logic [9:0]  pos;
    logic [31:0] data;
  } FIFO_PCIECFG_T;
endpackage

interface pciecfg_resp_tx_if;
  import pciecfg_resp_tx_pkg::*;

  logic          fifo_pciecfg_o_rd_en;
  logic          fifo_pciecfg_o_empty;
  FIFO_PCIECFG_T fifo_pciecfg_o_dout;
  logic          m_axis_tvalid;
  logic          m_axis_tready;
  logic [63:0]   m_axis_tdata;
  logic [7:0]    m_axis_tkeep;
  logic          m_axis_tlast;

  modport master (
    output fifo_pciecfg_o_rd_en,
    input  fifo_pciecfg_o_empty,
    input  fifo_pciecfg_o_dout,
    output m_axis_tvalid,
    input  m_axis_tready,
    output m_axis_tdata,
    output m_axis_tkeep,
    output m_axis_tlast
  );

  modport slave (
    input  fifo_pciecfg_o_rd_en,
    output fifo_pciecfg_o_empty,
    output fifo_pciecfg_o_dout,
    input  m_axis_tvalid,
    output m_axis_tready,
    input  m_axis_tdata,
    input  m_axis_tkeep,
    input  m_axis_tlast
  );
endinterface

// File: rtl/pciecfg_resp_tx.sv
// Serializes each popped config entry into a header beat plus a data beat; header valid one cycle after pop.
// Beats hold stable under tready=0 and the FIFO is only popped on IDLE or on the data-beat handshake.
module pciecfg_resp_tx
  import pciecfg_resp_tx_pkg::*;
#(
  parameter logic [15:0] MAGIC = 16'h5043
) (
  input  logic               clk,
  input  logic               rst_n,
  pciecfg_resp_tx_if.master  bus,
  output logic [31:0]        resp_cnt
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HDR  = 2'd1,
    DATA = 2'd2
  } state_e;

  state_e        state_q, state_d;
  FIFO_PCIECFG_T entry_q, entry_d;
  logic [7:0]    seq_q, seq_d;
  logic [31:0]   cnt_q, cnt_d;
  logic          pop;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      entry_q <= '0;
      seq_q   <= 8'h00;
      cnt_q   <= 32'h0;
    end else begin
      state_q <= state_d;
      entry_q <= entry_d;
      seq_q   <= seq_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    entry_d = entry_q;
    seq_d   = seq_q;
    cnt_d   = cnt_q;
    pop     = 1'b0;
    case (state_q)
      IDLE: begin
        if (!bus.fifo_pciecfg_o_empty) begin
          pop     = 1'b1;
          state_d = HDR;
        end
      end
      HDR: begin
        if (bus.m_axis_tready) state_d = DATA;
      end
      DATA: begin
        if (bus.m_axis_tready) begin
          seq_d = seq_q + 8'd1;
          cnt_d = cnt_q + 32'd1;
          // Refill straight from the data handshake so entries stream without a bubble.
          if (!bus.fifo_pciecfg_o_empty) begin
            pop     = 1'b1;
            state_d = HDR;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
    if (pop) entry_d = bus.fifo_pciecfg_o_dout;
  end

  always_comb begin
    bus.m_axis_tdata = 64'h0;
    case (state_q)
      HDR:     bus.m_axis_tdata = {MAGIC, 8'(entry_q.opcode), seq_q, 16'(entry_q.pos), 16'h0000};
      DATA:    bus.m_axis_tdata = {entry_q.data, 32'h0000_0000};
      default: bus.m_axis_tdata = 64'h0;
    endcase
  end

  // The FIFO is FWFT, so the pop strobe must be silent while reset holds the core.
  assign bus.fifo_pciecfg_o_rd_en = pop & rst_n;
  assign bus.m_axis_tvalid        = (state_q != IDLE);
  assign bus.m_axis_tlast         = (state_q == DATA);
  assign bus.m_axis_tkeep         = (state_q != IDLE) ? 8'hFF : 8'h00;
  assign resp_cnt                 = cnt_q;

endmodule

// File: tb/tb_pciecfg_resp_tx.sv
// Bench for pciecfg_resp_tx: FIFO model, beat capture, table vectors, directed corners and a random streaming run.
module tb_pciecfg_resp_tx;
  import pciecfg_resp_tx_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] resp_cnt;

  always #5 clk = ~clk;

  pciecfg_resp_tx_if bus();

  pciecfg_resp_tx #(.MAGIC(16'h5043)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .bus      (bus),
    .resp_cnt (resp_cnt)
  );

  typedef struct {
    logic [63:0] d;
    logic        l;
  } beat_t;

  typedef struct {
    logic [63:0] d;
    logic        l;
    int          c;
  } cap_t;

  typedef struct {
    logic [3:0]  op;
    logic [9:0]  pos;
    logic [31:0] data;
    logic [63:0] hdr;
    logic [63:0] dat;
  } vec_t;

  int n_chk = 0;
  int n_pass = 0;
  int cyc = 0;
  int pops = 0;
  int sent = 0;
  bit pop_pend = 1'b0;
  bit stall_prev = 1'b0;
  bit rnd_done = 1'b0;
  logic [63:0] prev_d;
  logic        prev_l;

  FIFO_PCIECFG_T fq[$];
  FIFO_PCIECFG_T push_q[$];
  beat_t         exp_q[$];
  cap_t          cap_q[$];
  int            pop_cyc_q[$];
  vec_t          tbl[4];

  function automatic void check(string name, logic [63:0] act, logic [63:0] req);
    n_chk++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got %h, required %h", name, act, req);
  endfunction

  // Reference: each entry becomes header then data, seq = response index since reset mod 256.
  function automatic void add_exp(FIFO_PCIECFG_T e);
    beat_t b;
    b.d = {16'h5043, 8'(e.opcode), 8'(sent), 16'(e.pos), 16'h0000};
    b.l = 1'b0;
    exp_q.push_back(b);
    b.d = {e.data, 32'h0};
    b.l = 1'b1;
    exp_q.push_back(b);
    sent++;
  endfunction

  task automatic push(FIFO_PCIECFG_T e);
    push_q.push_back(e);
    add_exp(e);
  endtask

  // FWFT FIFO model: pops decided at the previous negedge, new pushes land at this edge.
  always @(posedge clk) begin
    if (pop_pend && fq.size() > 0) void'(fq.pop_front());
    while (push_q.size() > 0) fq.push_back(push_q.pop_front());
    bus.fifo_pciecfg_o_empty <= (fq.size() == 0);
    bus.fifo_pciecfg_o_dout  <= (fq.size() != 0) ? fq[0] : '0;
  end

  always @(negedge clk) begin
    cyc++;
    pop_pend = bus.fifo_pciecfg_o_rd_en;
    if (bus.fifo_pciecfg_o_rd_en) begin
      pops++;
      pop_cyc_q.push_back(cyc);
      check("pop_while_empty", bus.fifo_pciecfg_o_empty, 1'b0);
    end
    if (bus.m_axis_tvalid) check("tkeep", bus.m_axis_tkeep, 8'hFF);
    if (stall_prev && rst_n) begin
      check("stall_tvalid", bus.m_axis_tvalid, 1'b1);
      check("stall_tdata", bus.m_axis_tdata, prev_d);
      check("stall_tlast", bus.m_axis_tlast, prev_l);
    end
    stall_prev = rst_n && bus.m_axis_tvalid && !bus.m_axis_tready;
    prev_d = bus.m_axis_tdata;
    prev_l = bus.m_axis_tlast;
    if (rst_n && bus.m_axis_tvalid && bus.m_axis_tready)
      cap_q.push_back('{bus.m_axis_tdata, bus.m_axis_tlast, cyc});
  end

  task automatic get_beat(output cap_t b);
    int t = 0;
    while (cap_q.size() == 0 && t < 200) begin
      @(posedge clk); #1;
      t++;
    end
    if (cap_q.size() == 0) begin
      check("beat_timeout", 1'b0, 1'b1);
      b = '{64'h0, 1'b0, 0};
    end else begin
      b = cap_q.pop_front();
    end
  endtask

  task automatic expect_model(string nm, output cap_t b);
    beat_t e;
    get_beat(b);
    if (exp_q.size() == 0) begin
      check({nm, "_unexpected_beat"}, 1'b1, 1'b0);
    end else begin
      e = exp_q.pop_front();
      check({nm, "_tdata"}, b.d, e.d);
      check({nm, "_tlast"}, b.l, e.l);
    end
  endtask

  task automatic wait_pops(int target);
    int t = 0;
    while (pops < target && t < 100) begin
      @(posedge clk); #1;
      t++;
    end
    check("pop_wait", pops >= target, 1'b1);
  endtask

  // Entries not yet popped survive reset; everything in flight is forgotten.
  task automatic rst_assert();
    rst_n = 1'b0;
    exp_q.delete();
    cap_q.delete();
    sent = 0;
    foreach (fq[i]) add_exp(fq[i]);
    foreach (push_q[i]) add_exp(push_q[i]);
  endtask

  task automatic rst_release();
    repeat (2) begin @(posedge clk); #1; end
    rst_n = 1'b1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, %0d/%0d", n_pass, n_chk);
    $fatal(1);
  end

  initial begin
    FIFO_PCIECFG_T e;
    cap_t b, h;
    cap_t b2b[6];
    int p0;

    tbl[0] = '{4'h1, 10'h004, 32'hDEADBEEF, 64'h5043_0100_0004_0000, 64'hDEADBEEF_0000_0000};
    tbl[1] = '{4'hF, 10'h3FF, 32'h12345678, 64'h5043_0F01_03FF_0000, 64'h12345678_0000_0000};
    tbl[2] = '{4'h0, 10'h000, 32'h00000000, 64'h5043_0002_0000_0000, 64'h00000000_0000_0000};
    tbl[3] = '{4'hA, 10'h155, 32'hFFFFFFFF, 64'h5043_0A03_0155_0000, 64'hFFFFFFFF_0000_0000};

    rst_n = 1'b0;
    bus.m_axis_tready = 1'b0;
    repeat (2) begin @(posedge clk); #1; end
    push('{tbl[0].op, tbl[0].pos, tbl[0].data});
    repeat (3) begin @(posedge clk); #1; end
    check("rst_rd_en", bus.fifo_pciecfg_o_rd_en, 1'b0);
    check("rst_tvalid", bus.m_axis_tvalid, 1'b0);
    check("rst_tlast", bus.m_axis_tlast, 1'b0);
    check("rst_tdata", bus.m_axis_tdata, 64'h0);
    check("rst_tkeep", bus.m_axis_tkeep, 8'h00);
    check("rst_resp_cnt", resp_cnt, 32'h0);

    rst_n = 1'b1;
    bus.m_axis_tready = 1'b1;
    @(posedge clk); #1;
    check("first_hdr_valid", bus.m_axis_tvalid, 1'b1);
    check("first_pop_count", pops, 1);

    for (int i = 0; i < 4; i++) begin
      if (i > 0) push('{tbl[i].op, tbl[i].pos, tbl[i].data});
      get_beat(b);
      check($sformatf("tbl%0d_hdr", i), b.d, tbl[i].hdr);
      check($sformatf("tbl%0d_hdr_tlast", i), b.l, 1'b0);
      get_beat(b);
      check($sformatf("tbl%0d_dat", i), b.d, tbl[i].dat);
      check($sformatf("tbl%0d_dat_tlast", i), b.l, 1'b1);
      check($sformatf("tbl%0d_resp_cnt", i), resp_cnt, 32'(i + 1));
      check($sformatf("tbl%0d_pops", i), pops, i + 1);
      if (exp_q.size() >= 2) begin
        void'(exp_q.pop_front());
        void'(exp_q.pop_front());
      end
    end

    // Backpressure: 5 stalled header cycles, then 3 stalled data cycles.
    bus.m_axis_tready = 1'b0;
    e = '{4'h3, 10'h0A5, 32'hCAFEF00D};
    push(e);
    wait_pops(5);
    p0 = pops;
    repeat (5) begin @(posedge clk); #1; end
    check("bp_hdr_valid", bus.m_axis_tvalid, 1'b1);
    check("bp_hdr_tlast", bus.m_axis_tlast, 1'b0);
    check("bp_hdr_no_pop", pops, p0);
    bus.m_axis_tready = 1'b1;
    expect_model("bp_hdr", b);
    bus.m_axis_tready = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
    check("bp_dat_tlast", bus.m_axis_tlast, 1'b1);
    check("bp_dat_no_pop", pops, p0);
    bus.m_axis_tready = 1'b1;
    expect_model("bp_dat", b);
    check("bp_resp_cnt", resp_cnt, 32'd5);

    // Back-to-back: three entries land together, stream at one beat per cycle.
    rst_assert();
    rst_release();
    bus.m_axis_tready = 1'b1;
    pop_cyc_q.delete();
    for (int k = 0; k < 3; k++) push('{4'(k + 5), 10'(k * 37), $urandom});
    for (int k = 0; k < 6; k++) expect_model($sformatf("b2b%0d", k), b2b[k]);
    for (int k = 0; k < 6; k++) check($sformatf("b2b%0d_cycle", k), b2b[k].c, b2b[0].c + k);
    for (int k = 0; k < 3; k++) check($sformatf("b2b%0d_seq", k), b2b[2 * k].d[39:32], 8'(k));
    check("b2b_pop_count", pop_cyc_q.size(), 3);
    if (pop_cyc_q.size() == 3) begin
      check("b2b_pop1_cycle", pop_cyc_q[1] - pop_cyc_q[0], 2);
      check("b2b_pop2_cycle", pop_cyc_q[2] - pop_cyc_q[0], 4);
      check("b2b_first_beat", b2b[0].c - pop_cyc_q[0], 1);
    end
    check("b2b_resp_cnt", resp_cnt, 32'd3);

    // Randomized streaming of 257 entries with a toggling tready, covering the seq wrap.
    rst_assert();
    rst_release();
    rnd_done = 1'b0;
    fork
      begin
        for (int k = 0; k < 257; k++) begin
          push('{4'($urandom), 10'($urandom), $urandom});
          repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
        end
      end
      begin
        while (!rnd_done) begin
          @(posedge clk); #1;
          bus.m_axis_tready = ($urandom_range(0, 3) != 0);
        end
      end
      begin
        for (int k = 0; k < 257; k++) begin
          expect_model($sformatf("rnd%0d_hdr", k), h);
          if (k == 255) check("wrap_seq_ff", h.d[39:32], 8'hFF);
          if (k == 256) check("wrap_seq_00", h.d[39:32], 8'h00);
          expect_model($sformatf("rnd%0d_dat", k), b);
        end
        rnd_done = 1'b1;
      end
    join
    bus.m_axis_tready = 1'b1;
    check("wrap_resp_cnt", resp_cnt, 32'd257);

    // Reset while the data beat is stalled; the next queued entry restarts at seq 0.
    @(posedge clk); #1;
    bus.m_axis_tready = 1'b0;
    p0 = pops;
    push('{4'h7, 10'h111, 32'hAAAA5555});
    wait_pops(p0 + 1);
    bus.m_axis_tready = 1'b1;
    expect_model("mid_hdr", b);
    bus.m_axis_tready = 1'b0;
    push('{4'h2, 10'h222, 32'h0BADC0DE});
    repeat (2) begin @(posedge clk); #1; end
    check("mid_dat_stalled", bus.m_axis_tlast, 1'b1);
    check("mid_no_pop", pops, p0 + 1);
    rst_assert();
    #1;
    check("mid_rst_tvalid", bus.m_axis_tvalid, 1'b0);
    check("mid_rst_tlast", bus.m_axis_tlast, 1'b0);
    check("mid_rst_resp_cnt", resp_cnt, 32'h0);
    rst_release();
    bus.m_axis_tready = 1'b1;
    expect_model("post_rst_hdr", b);
    check("post_rst_seq", b.d[39:32], 8'h00);
    expect_model("post_rst_dat", b);
    check("post_rst_pops", pops, p0 + 2);

    // Idle with an empty FIFO.
    repeat (2) begin @(posedge clk); #1; end
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      check("idle_tvalid", bus.m_axis_tvalid, 1'b0);
      check("idle_rd_en", bus.fifo_pciecfg_o_rd_en, 1'b0);
    end
    check("idle_no_leftover", cap_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/pciecfg_resp_tx.md
# pciecfg_resp_tx

Response serializer directly downstream of the PCIe config-access core. It pops completed config entries (FIFO_PCIECFG_T) from the pciecfg output FIFO and emits each entry as a fixed two-beat, 64-bit AXI-Stream response payload toward the Ethernet/UDP TX path. It adds a magic word and an 8-bit sequence number, and keeps a running response count.

## Interface
Parameters:
- MAGIC, 16'h5043, constant placed in header bits [63:48].

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst_n  in  1  reset, asynchronous assert, active-low.
- fifo_pciecfg_o_rd_en  out  1  pop strobe to the first-word-fall-through (FWFT) pciecfg output FIFO; combinational.
- fifo_pciecfg_o_empty  in  1  FIFO empty.
- fifo_pciecfg_o_dout  in  FIFO_PCIECFG_T  head entry; fields used: opcode, pos, data (32 bits).
- m_axis_tvalid  out  1  stream valid.
- m_axis_tready  in  1  stream ready.
- m_axis_tdata  out  64  payload beat.
- m_axis_tkeep  out  8  byte enables; always 8'hFF while valid.
- m_axis_tlast  out  1  marks the second beat.
- resp_cnt  out  32  number of responses fully accepted (tlast handshakes).

One clock; reset is asynchronous and active-low.

## Operation
- States: IDLE, HDR, DATA.
- Entry register: holds the opcode, pos and data fields. Sequence register seq is 8 bits.

State transitions:
- IDLE: when fifo_pciecfg_o_empty=0, assert rd_en for this cycle, latch dout into the entry register, go to HDR.
- HDR: drive the header beat with tvalid=1 and tlast=0. On tvalid&&tready, go to DATA.
- DATA: drive the data beat with tvalid=1 and tlast=1. On tvalid&&tready:
  - seq increments by 1, wrapping 8'hFF -> 8'h00.
  - resp_cnt increments by 1, wrapping 2^32-1 -> 0.
  - If empty=0 in the same cycle: assert rd_en, latch dout, go to HDR (back-to-back, no bubble).
  - Otherwise go to IDLE.
- rd_en equation: (IDLE && !empty) || (DATA && tready && !empty). It is never asserted when empty=1, and it fires exactly once per entry.

Beat formats:
- Header beat: [63:48]=MAGIC, [47:40]=opcode zero-extended to 8 bits, [39:32]=seq, [31:16]=pos zero-extended to 16 bits, [15:0]=16'h0000.
- Data beat: [63:32]=data, [31:0]=32'h0.

Other rules:
- Every opcode is forwarded unfiltered.
- While tvalid=1 and tready=0: tdata, tkeep and tlast hold stable, and no pop occurs.
- tvalid, once asserted, is not deasserted until the handshake completes.

## Timing
- Reset values (while rst_n=0): state=IDLE, tvalid=0, tlast=0, tdata=0, tkeep=0, rd_en=0, seq=0, resp_cnt=0, entry register=0.
- Reset mid-packet: the in-flight entry is discarded, the packet is truncated with no tlast, and seq restarts at 0.
- First beat after reset: the first beat can issue on the second rising edge after rst_n deasserts.
- Latency: empty falls in IDLE at cycle N -> header beat valid at cycle N+1 -> data beat at N+2 if tready=1 throughout.
- Throughput: 2 beats per entry; sustained 1 beat/cycle with tready=1 and a non-empty FIFO.
- Simultaneous data-beat handshake and non-empty FIFO: the pop and the seq increment both take effect that cycle. The next header carries the incremented seq.
- empty rising while in HDR or DATA: no effect on the current packet.
- tready is allowed to toggle on any cycle; only cycles with tvalid&&tready advance state.

## Test plan
- Single entry (opcode=1, pos=10'h004, data=32'hDEADBEEF), tready=1:
  - header = 64'h5043_01_00_0004_0000, then data beat = 64'hDEADBEEF_00000000 with tlast=1.
  - rd_en pulses exactly 1 cycle; resp_cnt=1.
- Backpressure: tready=0 for 5 cycles during HDR, then 3 cycles during DATA:
  - tdata, tkeep and tlast stay stable throughout.
  - No rd_en pulses; beats complete once tready=1.
- Back-to-back: 3 entries preloaded, tready=1:
  - 6 consecutive valid beats, tlast on beats 2, 4 and 6.
  - seq fields 00, 01, 02; rd_en pulses in cycles 0, 2 and 4 relative to the first pop; resp_cnt=3.
- Sequence wrap: 257 entries streamed:
  - entry 256 header carries seq 8'hFF; entry 257 carries 8'h00.
  - resp_cnt=257.
- Reset mid-packet: rst_n=0 during DATA with tready=0:
  - tvalid drops immediately and seq=0.
  - After release, the next FIFO entry produces a header with seq 8'h00; the dropped entry is not replayed.
- Empty FIFO idle: empty=1 for 20 cycles -> tvalid=0 and rd_en=0 throughout.
